// File: rtl/flappy_pkg.sv
// flappy_pkg: one-hot state encoding and default physics constants shared
// by the bird controller and the renderer.
package flappy_pkg;
  typedef enum logic [4:0] {
    S_I       = 5'b00001,
    S_GRAV    = 5'b00010,
    S_FLAP    = 5'b00100,
    S_UNPRESS = 5'b01000,
    S_LOST    = 5'b10000
  } state_t;
  localparam int YW_D      = 10;
  localparam int VW_D      = 6;
  localparam int Y_START_D = 240;
  localparam int Y_MAX_D   = 464;
  localparam int GRAV_D    = 1;
  localparam int FLAP_V_D  = -8;
  localparam int V_MAX_D   = 12;
  localparam int SCORE_W_D = 8;
endpackage

// File: rtl/flappy_phys_step.sv
// flappy_phys_step: one physics step -- gravity with terminal velocity (or flap
// impulse), then ceiling clamp and floor detection on the new row.
module flappy_phys_step import flappy_pkg::*; #(
  parameter int YW     = YW_D,
  parameter int VW     = VW_D,
  parameter int Y_MAX  = Y_MAX_D,
  parameter int GRAV   = GRAV_D,
  parameter int FLAP_V = FLAP_V_D,
  parameter int V_MAX  = V_MAX_D
) (
  input  logic [YW-1:0]        y,
  input  logic signed [VW-1:0] vel,
  input  logic                 load_flap,
  output logic [YW-1:0]        ny,
  output logic signed [VW-1:0] nv,
  output logic                 floor_hit
);
  logic signed [VW:0]   vs;
  logic signed [VW-1:0] vn;
  logic signed [YW+1:0] s;
  logic                 neg;
  always_comb begin
    vs = (VW+1)'(vel) + (VW+1)'(GRAV);
    vn = load_flap ? VW'(FLAP_V) : (vs > (VW+1)'(V_MAX)) ? VW'(V_MAX) : vs[VW-1:0];
    s = (YW+2)'(y) + (YW+2)'(vn);
    neg = s[YW+1];
    floor_hit = !neg && (s >= (YW+2)'(Y_MAX));
    ny = neg ? '0 : floor_hit ? YW'(Y_MAX) : s[YW-1:0];
    nv = neg ? '0 : vn;
  end
endmodule

// File: rtl/flappy_bird_ctrl.sv
// flappy_bird_ctrl: bird game FSM, per-tick physics integration and score.
module flappy_bird_ctrl import flappy_pkg::*; #(
  parameter int YW      = YW_D,
  parameter int VW      = VW_D,
  parameter int Y_START = Y_START_D,
  parameter int Y_MAX   = Y_MAX_D,
  parameter int GRAV    = GRAV_D,
  parameter int FLAP_V  = FLAP_V_D,
  parameter int V_MAX   = V_MAX_D,
  parameter int SCORE_W = SCORE_W_D
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Ack,
  input  logic               Flap,
  input  logic               Pipe_Hit,
  input  logic               Pipe_Passed,
  output logic [YW-1:0]      YBird,
  output logic [SCORE_W-1:0] Score,
  output logic               q_I,
  output logic               q_Grav,
  output logic               q_Flap,
  output logic               q_UnPress,
  output logic               q_Lost
);
  state_t               state, state_n;
  logic signed [VW-1:0] vel, vel_n, nv;
  logic [YW-1:0]        y_n, ny;
  logic [SCORE_W-1:0]   score_n;
  logic                 floor_hit, playing;
  flappy_phys_step #(.YW(YW), .VW(VW), .Y_MAX(Y_MAX), .GRAV(GRAV), .FLAP_V(FLAP_V), .V_MAX(V_MAX)) u_phys (
    .y(YBird), .vel(vel), .load_flap(state == S_FLAP), .ny(ny), .nv(nv), .floor_hit(floor_hit)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= S_I;
      YBird <= YW'(Y_START);
      vel <= '0;
      Score <= '0;
    end else begin
      state <= state_n;
      YBird <= y_n;
      vel <= vel_n;
      Score <= score_n;
    end
  assign playing = (state == S_GRAV) || (state == S_FLAP) || (state == S_UNPRESS);
  always_comb begin
    state_n = state;
    y_n = YBird;
    vel_n = vel;
    score_n = (playing && Pipe_Passed && !(&Score)) ? Score + 1'b1 : Score;
    case (state)
      S_I: begin
        y_n = YW'(Y_START);
        vel_n = '0;
        score_n = '0;
        if (Start) state_n = S_GRAV;
      end
      S_GRAV, S_UNPRESS: begin
        if (Tick) begin
          y_n = ny;
          vel_n = nv;
        end
        state_n = (Pipe_Hit || (Tick && floor_hit)) ? S_LOST :
                  (state == S_GRAV && Flap) ? S_FLAP :
                  (state == S_UNPRESS && !Flap) ? S_GRAV : state;
      end
      S_FLAP: begin
        // without a tick only the impulse is loaded; the ceiling clamp needs a move
        y_n = Tick ? ny : YBird;
        vel_n = Tick ? nv : VW'(FLAP_V);
        state_n = Pipe_Hit ? S_LOST : S_UNPRESS;
      end
      S_LOST:
        if (Ack) begin
          state_n = S_I;
          y_n = YW'(Y_START);
          vel_n = '0;
          score_n = '0;
        end
      default: state_n = S_I;
    endcase
  end
  assign {q_Lost, q_UnPress, q_Flap, q_Grav, q_I} = state;
endmodule

// File: tb/tb_flappy_bird_ctrl.sv
// tb_flappy_bird_ctrl: directed plus random stimulus on a default and an
// overridden (Y_START=4, SCORE_W=2) instance, checked against a game model.
module tb_flappy_bird_ctrl;
  logic Clk = 0, Reset, Tick, Start, Ack, Flap, Pipe_Hit, Pipe_Passed;
  logic [9:0] y1, y2;
  logic [7:0] sc1;
  logic [1:0] sc2;
  logic [4:0] q1, q2;
  int checks = 0, errors = 0;
  int saved_y;
  typedef struct {int st; int y; int v; int sc;} mdl_t;
  mdl_t m1, m2;
  always #5 Clk = ~Clk;
  flappy_bird_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Ack(Ack), .Flap(Flap),
    .Pipe_Hit(Pipe_Hit), .Pipe_Passed(Pipe_Passed), .YBird(y1), .Score(sc1),
    .q_I(q1[0]), .q_Grav(q1[1]), .q_Flap(q1[2]), .q_UnPress(q1[3]), .q_Lost(q1[4])
  );
  flappy_bird_ctrl #(.Y_START(4), .SCORE_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Ack(Ack), .Flap(Flap),
    .Pipe_Hit(Pipe_Hit), .Pipe_Passed(Pipe_Passed), .YBird(y2), .Score(sc2),
    .q_I(q2[0]), .q_Grav(q2[1]), .q_Flap(q2[2]), .q_UnPress(q2[3]), .q_Lost(q2[4])
  );
  // model states: 0 idle, 1 falling, 2 flap, 3 wait-release, 4 lost
  function automatic mdl_t mreset(int ys);
    mdl_t r;
    r.st = 0; r.y = ys; r.v = 0; r.sc = 0;
    return r;
  endfunction
  function automatic mdl_t mstep(mdl_t m, bit s, bit a, bit f, bit h, bit p, bit t, int ys, int scmax);
    mdl_t r = m;
    int nv, ny;
    bit fl = 0;
    if (m.st >= 1 && m.st <= 3 && p && m.sc < scmax) r.sc = m.sc + 1;
    if (m.st == 0) begin
      r = mreset(ys);
      if (s) r.st = 1;
    end else if (m.st == 1 || m.st == 3) begin
      if (t) begin
        nv = (m.v + 1 > 12) ? 12 : m.v + 1;
        ny = m.y + nv;
        if (ny < 0) begin r.y = 0; r.v = 0; end
        else if (ny >= 464) begin r.y = 464; r.v = nv; fl = 1; end
        else begin r.y = ny; r.v = nv; end
      end
      if (h || fl) r.st = 4;
      else if (m.st == 1 && f) r.st = 2;
      else if (m.st == 3 && !f) r.st = 1;
    end else if (m.st == 2) begin
      r.v = -8;
      if (t) begin
        ny = m.y - 8;
        if (ny < 0) begin r.y = 0; r.v = 0; end
        else r.y = ny;
      end
      r.st = h ? 4 : 3;
    end else if (a) begin
      r = mreset(ys);
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("state1", 32'(q1), 32'(1 << m1.st));
    chk("ybird1", 32'(y1), 32'(m1.y));
    chk("score1", 32'(sc1), 32'(m1.sc));
    chk("state2", 32'(q2), 32'(1 << m2.st));
    chk("ybird2", 32'(y2), 32'(m2.y));
    chk("score2", 32'(sc2), 32'(m2.sc));
  endtask
  task automatic step(input bit s, input bit a, input bit f, input bit h, input bit p, input bit t);
    Start = s; Ack = a; Flap = f; Pipe_Hit = h; Pipe_Passed = p; Tick = t;
    @(posedge Clk);
    m1 = mstep(m1, s, a, f, h, p, t, 240, 255);
    m2 = mstep(m2, s, a, f, h, p, t, 4, 3);
    #1;
    check_all();
  endtask
  initial begin
    {Start, Ack, Flap, Pipe_Hit, Pipe_Passed, Tick} = '0;
    Reset = 1;
    m1 = mreset(240);
    m2 = mreset(4);
    #2;
    check_all();
    @(negedge Clk) Reset = 0;
    step(1, 0, 0, 0, 0, 0);
    chk("start_grav", 32'(q1[1]), 1);
    step(0, 0, 0, 0, 0, 1); chk("fall_t1", 32'(y1), 241);
    step(0, 0, 0, 0, 0, 1); chk("fall_t2", 32'(y1), 243);
    step(0, 0, 0, 0, 0, 1); chk("fall_t3", 32'(y1), 246);
    chk("ovr_t3", 32'(y2), 10);
    step(0, 0, 1, 0, 0, 0); chk("flap_state", 32'(q1[2]), 1);
    step(0, 0, 1, 0, 0, 0); chk("unpress_state", 32'(q1[3]), 1);
    step(0, 0, 1, 0, 0, 1); chk("flap_tick1", 32'(y1), 239);
    step(0, 0, 1, 0, 0, 1); chk("ceiling_y", 32'(y2), 0);
    chk("ceiling_unpress", 32'(q2[3]), 1);
    repeat (3) step(0, 0, 1, 0, 0, 1);
    chk("no_reflap", 32'(q1[3]), 1);
    step(0, 0, 0, 0, 0, 0); chk("release_grav", 32'(q1[1]), 1);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("score3", 32'(sc1), 3);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    chk("score5", 32'(sc1), 5);
    chk("score_sat", 32'(sc2), 3);
    step(0, 0, 1, 1, 0, 1);
    chk("hit_lost", 32'(q1[4]), 1);
    saved_y = 32'(y1);
    repeat (4) step(1, 0, 1, 0, 1, 1);
    chk("lost_y_frozen", 32'(y1), 32'(saved_y));
    chk("lost_score_frozen", 32'(sc1), 5);
    step(0, 1, 0, 0, 0, 0);
    chk("ack_idle", 32'(q1[0]), 1);
    chk("ack_y", 32'(y1), 240);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (i == 12) chk("vmax_y", 32'(y1), 318);
      if (i == 24) chk("tick24_y", 32'(y1), 462);
    end
    chk("floor_y", 32'(y1), 464);
    chk("floor_lost", 32'(q1[4]), 1);
    step(0, 1, 0, 0, 0, 0);
    chk("floor_ack_y", 32'(y1), 240);
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1, 1);
    @(negedge Clk);
    #1 Reset = 1;
    m1 = mreset(240);
    m2 = mreset(4);
    #1;
    chk("async_rst_q", 32'(q1), 1);
    chk("async_rst_y", 32'(y1), 240);
    chk("async_rst_sc", 32'(sc1), 0);
    check_all();
    @(negedge Clk) Reset = 0;
    repeat (800)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
